// File: rtl/ij_input_conditioner_pkg.sv
// Shared types and constants for the i/j input conditioner.
package ij_cond_pkg;

  // Per-channel debounce state.
  typedef enum logic {
    DB_STABLE  = 1'b0,
    DB_PENDING = 1'b1
  } db_state_t;

  // Width of the glitch counter and its saturation value.
  localparam int GLITCH_W = 8;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

endpackage

// File: rtl/ij_input_conditioner_if.sv
// Bundles the raw inputs and conditioned outputs of the conditioner.
// The slave side is the conditioner; the master side drives raw levels
// and consumes the clean i/j levels plus debug status.
interface ij_input_conditioner_if
  import ij_cond_pkg::*;
  ();

  logic                i_raw;
  logic                j_raw;
  logic                i;
  logic                j;
  logic                ij_changed;
  logic [GLITCH_W-1:0] glitch_cnt;

  modport master (
    output i_raw,
    output j_raw,
    input  i,
    input  j,
    input  ij_changed,
    input  glitch_cnt
  );

  modport slave (
    input  i_raw,
    input  j_raw,
    output i,
    output j,
    output ij_changed,
    output glitch_cnt
  );

endinterface

// File: rtl/ij_input_conditioner_db_channel.sv
// One conditioning channel: synchronizer chain, debounce counter and a
// two-state debounce FSM. toggled/glitch are strobes describing what the
// current edge will do, so the parent can register them alongside out.
module db_channel
  import ij_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic out,
  output logic toggled,
  output logic glitch
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;
  db_state_t              state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic                   out_reg, out_next;

  assign s   = sync_reg[SYNC_STAGES-1];
  assign out = out_reg;

  // Synchronizer chain: raw enters at bit 0, s leaves from the top bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_reg <= '0;
    else       sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
  end

  // Debounce state, counter and output level registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= DB_STABLE;
      cnt_reg   <= '0;
      out_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
    end
  end

  // Next-state logic: s must disagree with out for DEBOUNCE consecutive
  // edges before out follows; falling back early counts as a glitch.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    out_next   = out_reg;
    glitch     = 1'b0;
    case (state_reg)
      DB_STABLE: begin
        if (s != out_reg) begin
          if (DEBOUNCE == 1) begin
            out_next = s;
            cnt_next = '0;
          end else begin
            state_next = DB_PENDING;
            cnt_next   = CW'(1);
          end
        end else begin
          cnt_next = '0;
        end
      end
      DB_PENDING: begin
        if (s != out_reg) begin
          if (cnt_reg == CNT_LAST) begin
            out_next   = s;
            cnt_next   = '0;
            state_next = DB_STABLE;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end else begin
          cnt_next   = '0;
          state_next = DB_STABLE;
          glitch     = 1'b1;
        end
      end
      default: begin
        state_next = DB_STABLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign toggled = (out_next != out_reg);

endmodule

// File: rtl/ij_input_conditioner.sv
// Conditions the raw i/j control levels for the downstream FSM: two
// debounce channels, a registered change pulse and a saturating count
// of rejected glitches. Every output is driven directly by a flop.
module ij_input_conditioner
  import ij_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  ij_input_conditioner_if.slave  cond
);

  localparam int SUM_W = GLITCH_W + 1;

  logic                i_out, j_out;
  logic                i_toggled, j_toggled;
  logic                i_glitch, j_glitch;
  logic                ij_changed_reg;
  logic [GLITCH_W-1:0] glitch_cnt_reg, glitch_cnt_next;
  logic [SUM_W-1:0]    glitch_sum;

  db_channel #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE    (DEBOUNCE)
  ) u_chan_i (
    .clk     (clk),
    .rstn    (rstn),
    .raw     (cond.i_raw),
    .out     (i_out),
    .toggled (i_toggled),
    .glitch  (i_glitch)
  );

  db_channel #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE    (DEBOUNCE)
  ) u_chan_j (
    .clk     (clk),
    .rstn    (rstn),
    .raw     (cond.j_raw),
    .out     (j_out),
    .toggled (j_toggled),
    .glitch  (j_glitch)
  );

  // Add 0, 1 or 2 glitch events, clamping at the counter maximum.
  always_comb begin
    glitch_sum      = {1'b0, glitch_cnt_reg} + SUM_W'(i_glitch) + SUM_W'(j_glitch);
    glitch_cnt_next = glitch_sum[GLITCH_W] ? GLITCH_MAX : glitch_sum[GLITCH_W-1:0];
  end

  // Change pulse lines up with the new i/j level; glitch count register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ij_changed_reg <= 1'b0;
      glitch_cnt_reg <= '0;
    end else begin
      ij_changed_reg <= i_toggled | j_toggled;
      glitch_cnt_reg <= glitch_cnt_next;
    end
  end

  assign cond.i          = i_out;
  assign cond.j          = j_out;
  assign cond.ij_changed = ij_changed_reg;
  assign cond.glitch_cnt = glitch_cnt_reg;

endmodule
